// File: rtl/vga_obj_pkg.sv
// Shared types and encodings for the VGA rectangle-object scheduler.
// Field select codes, attr bit positions, the obj_t descriptor and default parameters.
package vga_obj_pkg;

  localparam int OBJ_CW = 10;
  localparam int N_OBJ_DEF = 4;
  localparam logic [2:0] BG_RGB_DEF = 3'b001;

  localparam logic [2:0] FLD_X    = 3'd0;
  localparam logic [2:0] FLD_Y    = 3'd1;
  localparam logic [2:0] FLD_W    = 3'd2;
  localparam logic [2:0] FLD_H    = 3'd3;
  localparam logic [2:0] FLD_ATTR = 3'd4;

  localparam int ATTR_RGB_LSB = 0;
  localparam int ATTR_EN      = 3;
  localparam int ATTR_OUTLINE = 4;

  typedef struct packed {
    logic [OBJ_CW-1:0] ox;
    logic [OBJ_CW-1:0] oy;
    logic [OBJ_CW-1:0] w;
    logic [OBJ_CW-1:0] h;
    logic              en;
    logic [2:0]        rgb;
    logic              outline;
  } obj_t;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

endpackage

// File: rtl/vga_obj_hit.sv
// Combinational hit test of one rectangle against the current pixel; zero latency, no flow control.
// VGA_OBJ_SCHED_OUTLINE_EN makes outline objects hit only within 2 pixels of their edge.
module vga_obj_hit
  import vga_obj_pkg::*;
(
  input  obj_t              obj,
  input  logic [OBJ_CW-1:0] pix_x,
  input  logic [OBJ_CW-1:0] pix_y,
  output logic              hit
);

  localparam logic [OBJ_CW:0] TWO = (OBJ_CW+1)'(2);

  // One extra bit so origin + size never wraps; off-screen parts simply never match.
  logic [OBJ_CW:0] x, y, x_end, y_end;
  logic            in_rect;

  assign x     = {1'b0, pix_x};
  assign y     = {1'b0, pix_y};
  assign x_end = {1'b0, obj.ox} + {1'b0, obj.w};
  assign y_end = {1'b0, obj.oy} + {1'b0, obj.h};

  assign in_rect = obj.en && (pix_x >= obj.ox) && (x < x_end)
                          && (pix_y >= obj.oy) && (y < y_end);

`ifdef VGA_OBJ_SCHED_OUTLINE_EN
  logic near_edge;
  // Far edges compared as x + 2 >= end to avoid underflow on tiny objects.
  assign near_edge = (x < {1'b0, obj.ox} + TWO) || (x + TWO >= x_end)
                  || (y < {1'b0, obj.oy} + TWO) || (y + TWO >= y_end);
  assign hit = in_rect && (!obj.outline || near_edge);
`else
  logic unused_outline;
  assign unused_outline = obj.outline ^ TWO[1];
  assign hit = in_rect;
`endif

endmodule

// File: rtl/vga_obj_scheduler.sv
// Round-robin req/gnt writes into shadow object registers, committed on frame_start; composites objects over BG.
// Pixel path 1 cycle latency; one write per 2 cycles, requesters hold until gnt. Option: VGA_OBJ_SCHED_OUTLINE_EN.
module vga_obj_scheduler
  import vga_obj_pkg::*;
#(
  parameter int         N_OBJ  = N_OBJ_DEF,
  parameter int         CW     = OBJ_CW,
  parameter logic [2:0] BG_RGB = BG_RGB_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_valid,
  input  logic [CW-1:0] pix_x,
  input  logic [CW-1:0] pix_y,
  input  logic          frame_start,
  input  logic          req0,
  input  logic          req1,
  input  logic [1:0]    obj0,
  input  logic [1:0]    obj1,
  input  logic [2:0]    fld0,
  input  logic [2:0]    fld1,
  input  logic [CW-1:0] dat0,
  input  logic [CW-1:0] dat1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          pending,
  output logic          vga_r,
  output logic          vga_g,
  output logic          vga_b
);

  arb_state_t state, state_nxt;
  logic       sel, sel_nxt;     // requester owning the current/next grant
  logic       last, last_nxt;   // requester granted most recently

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
      sel   <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    last_nxt  = last;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (req0 || req1) begin
          state_nxt = ARB_GRANT;
          sel_nxt   = (req0 && req1) ? ~last : req1;
        end
      end
      ARB_GRANT: begin
        gnt0      = ~sel;
        gnt1      = sel;
        last_nxt  = sel;
        state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  logic          wr_valid;
  logic [1:0]    wr_obj;
  logic [2:0]    wr_fld;
  logic [CW-1:0] wr_dat;

  assign wr_obj   = sel ? obj1 : obj0;
  assign wr_fld   = sel ? fld1 : fld0;
  assign wr_dat   = sel ? dat1 : dat0;
  assign wr_valid = (state == ARB_GRANT) && (wr_fld <= FLD_ATTR);

  obj_t shadow [N_OBJ];
  obj_t active [N_OBJ];

  // Non-blocking copy means a same-cycle write stays in shadow and misses this commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_OBJ; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      pending <= 1'b0;
    end else begin
      if (frame_start) active <= shadow;
      if (wr_valid) begin
        pending <= 1'b1;
        case (wr_fld)
          FLD_X:   shadow[wr_obj].ox <= wr_dat;
          FLD_Y:   shadow[wr_obj].oy <= wr_dat;
          FLD_W:   shadow[wr_obj].w  <= wr_dat;
          FLD_H:   shadow[wr_obj].h  <= wr_dat;
          default: begin
            shadow[wr_obj].en      <= wr_dat[ATTR_EN];
            shadow[wr_obj].rgb     <= wr_dat[ATTR_RGB_LSB +: 3];
            shadow[wr_obj].outline <= wr_dat[ATTR_OUTLINE];
          end
        endcase
      end else if (frame_start) begin
        pending <= 1'b0;
      end
    end
  end

  logic [N_OBJ-1:0] hit;

  for (genvar i = 0; i < N_OBJ; i++) begin : g_hit
    vga_obj_hit u_hit (
      .obj   (active[i]),
      .pix_x (pix_x),
      .pix_y (pix_y),
      .hit   (hit[i])
    );
  end

  logic [2:0] rgb_nxt;

  always_comb begin
    rgb_nxt = BG_RGB;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (hit[i]) rgb_nxt = active[i].rgb;
    end
    if (!pix_valid) rgb_nxt = 3'b000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {vga_r, vga_g, vga_b} <= 3'b000;
    else        {vga_r, vga_g, vga_b} <= rgb_nxt;
  end

endmodule

// File: doc/vga_obj_scheduler.md
# vga_obj_scheduler

Shared-resource controller for the 800x600 VGA pixel path. Two requesters (e.g. a key handler and a demo sequencer) write rectangle-object descriptors through a round-robin-arbitrated req/gnt port into shadow registers. The shadow registers are committed to the active set only at frame start. The block composites up to N_OBJ rectangles over a fixed background into 1-bit-per-channel RGB, and sits between the VGA timing generator and the pins.

## Interface
- N_OBJ, 4, number of rectangle objects; index 0 has the highest priority.
- CW, 10, coordinate width for x, y, width and height.
- BG_RGB, 3'b001, background colour {r,g,b} for valid pixels not covered by any object.

- clk  in  1  pixel clock, 50 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- pix_valid  in  1  timing generator is inside the active area.
- pix_x  in  CW  active-area x, 0..799.
- pix_y  in  CW  active-area y, 0..599.
- frame_start  in  1  one-cycle pulse during vertical sync. This is the commit strobe.
- req0, req1  in  1  write requests.
- obj0, obj1  in  2  object index of the write.
- fld0, fld1  in  3  field select: 0 = x origin, 1 = y origin, 2 = width, 3 = height, 4 = attr.
- dat0, dat1  in  CW  write data. For attr: bit3 = enable, bits2:0 = {r,g,b}, bit4 = outline (see Configuration).
- gnt0, gnt1  out  1  one-cycle grant. The write is performed in the grant cycle.
- pending  out  1  shadow registers differ from the active set (a write has happened since the last commit).
- vga_r, vga_g, vga_b  out  1  registered colour outputs.

## Operation
- Arbiter FSM has two states:
  - IDLE: at each edge, if any req is high, go to GRANT. Select per the round-robin pointer: with both requests high, the requester not granted last wins. After reset the pointer favours requester 0.
  - GRANT: the selected gnt is high for exactly one cycle. The shadow field is written at the end of the cycle. The pointer updates. Return to IDLE.
- Requesters hold req, obj, fld and dat stable until they see gnt, then drop req at the next edge. Maximum rate is one write per 2 cycles.
- Writes with fld greater than 4 are acknowledged (gnt pulses) but discarded.
- On frame_start:
  - All shadow registers are copied to the active registers.
  - pending clears.
  - If a GRANT write lands in the same cycle, the copy uses the pre-write shadow value. The write stays in shadow and pending is set.
- Any GRANT write sets pending.
- Hit test uses the active set only: hit_i = en_i && x >= ox_i && x < ox_i + w_i && y >= oy_i && y < oy_i + h_i.
  - Sums are computed at CW+1 bits, with no wrap.
  - w = 0 or h = 0 never hits.
  - Objects extending past 799/599 are clipped naturally.
- Colour selection:
  - Lowest-index hit wins and outputs its rgb.
  - No hit: output BG_RGB.
  - pix_valid low: output 3'b000.

## Timing
- Reset values:
  - gnt0 = gnt1 = 0, pending = 0, FSM = IDLE.
  - All shadow and active registers are 0 (all objects disabled).
  - vga_r, vga_g, vga_b = 0.
- Pixel latency is exactly 1 cycle from pix_x/pix_y/pix_valid to the RGB outputs. The timing generator delays hsync/vsync by one cycle to match.
- Grant latency: req sampled high in IDLE → gnt high in the next cycle.
- Reset mid-GRANT: the write is dropped and gnt goes low immediately (asynchronous).
- Active registers change only on frame_start, so no tearing occurs within a frame.

## Configuration
- VGA_OBJ_SCHED_OUTLINE_EN defined: attr bit4 = outline.
  - An outline object hits only when the pixel is inside its rectangle and within 2 pixels of its edge: x < ox+2 || x >= ox+w-2 || y < oy+2 || y >= oy+h-2.
  - Outline hits suppress interior pixels, so lower-priority objects show through the interior.
- Undefined: attr bit4 is stored but ignored, and all objects are filled.

## Structure
- Package vga_obj_pkg holds:
  - field encodings FLD_X, FLD_Y, FLD_W, FLD_H, FLD_ATTR;
  - the attr bit positions;
  - a packed obj_t struct {ox, oy, w, h, en, rgb, outline};
  - the default N_OBJ and BG_RGB.
- Sub-module vga_obj_hit: combinational hit test for one obj_t against pix_x/pix_y, instantiated N_OBJ times. The priority mux and registers live in the top level.

## Test plan
- Reset, pix_valid = 1 at (0,0) → RGB = 001 one cycle later; gnt = 0; pending = 0.
- req0 writes obj0: x = 100, y = 100, w = 50, h = 20, attr = 0x0C (en, red); then frame_start.
  - Pixel (100,100) → 100; (149,119) → 100; (150,100) → 001.
  - Before the commit, all of these pixels → 001.
- req0 and req1 asserted together continuously → gnt1, gnt0, gnt1, gnt0… alternating; never both high; at most one gnt per 2 cycles.
- Overlap: obj0 green at (10,10,20,20) and obj1 red at (0,0,40,40).
  - Pixel (15,15) → 010; (5,5) → 100.
- Write granted in the same cycle as frame_start → not visible this frame; pending = 1; visible after the next frame_start.
- With VGA_OBJ_SCHED_OUTLINE_EN, obj0 outline at (0,0,10,10) over BG → (1,5) → obj colour; (5,5) → 001; (8,5) → obj colour.
